// File: rtl/fir_uart_ctrl.sv
// Sequencer between UART RX/TX and the FIR: RX bytes become FIR samples, FIR results are queued and sent.
// Define FIR_UART_CTRL_SAT8_EN to send each result as one byte, saturated to signed DATA_W.
module fir_uart_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RES_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [DATA_W-1:0]             i_rx_data,
  input  logic                          i_rx_done,
  output logic [DATA_W-1:0]             o_fir_in,
  output logic                          o_fir_in_valid,
  input  logic [RES_W-1:0]              i_fir_out,
  input  logic                          i_fir_out_valid,
  output logic [DATA_W-1:0]             o_tx_data,
  output logic                          o_tx_start,
  input  logic                          i_tx_busy,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSendHi,
    StWaitHiAck,
    StWaitHiDone,
    StSendLo,
    StWaitLoAck,
    StWaitLoDone
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_fir_in;
  logic              r_fir_in_valid;
  logic [RES_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_tx_data;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [RES_W-1:0]  w_head;
  logic [DATA_W-1:0] w_first_byte;

  // Sample path
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fir_in       <= '0;
      r_fir_in_valid <= 1'b0;
    end else begin
      r_fir_in_valid <= i_rx_done & i_start;
      if (i_rx_done && i_start) begin
        r_fir_in <= i_rx_data;
      end
    end
  end

  // Result FIFO; LOAD only ever follows a non-empty IDLE, so pop never underflows.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);
  assign w_pop   = (r_state == StLoad);
  assign w_push  = i_fir_out_valid & (~w_full | w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_fir_out;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + (PTR_W + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (PTR_W + 1)'(1);
      end
      if (i_fir_out_valid && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef FIR_UART_CTRL_SAT8_EN
  // Fits in signed DATA_W when every bit from the DATA_W-1 position up equals the sign.
  logic [RES_W-DATA_W:0] w_upper;
  assign w_upper = w_head[RES_W-1:DATA_W-1];

  always_comb begin
    w_first_byte = w_head[DATA_W-1:0];
    if (!((&w_upper) || !(|w_upper))) begin
      w_first_byte = w_head[RES_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic [DATA_W-1:0] r_hold_lo;
  assign w_first_byte = w_head[RES_W-1:DATA_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_lo <= '0;
    end else if (w_pop) begin
      r_hold_lo <= w_head[DATA_W-1:0];
    end
  end
`endif

  // tx_data is loaded ahead of each SEND state and held until the next byte is due.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_data <= '0;
    end else if (w_pop) begin
      r_tx_data <= w_first_byte;
`ifndef FIR_UART_CTRL_SAT8_EN
    end else if (r_state == StWaitHiDone && !i_tx_busy) begin
      r_tx_data <= r_hold_lo;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_empty && !i_tx_busy) w_state_next = StLoad;
      end
`ifdef FIR_UART_CTRL_SAT8_EN
      StLoad:       w_state_next = StSendLo;
`else
      StLoad:       w_state_next = StSendHi;
`endif
      StSendHi:     w_state_next = StWaitHiAck;
      StWaitHiAck:  if (i_tx_busy) w_state_next = StWaitHiDone;
      StWaitHiDone: if (!i_tx_busy) w_state_next = StSendLo;
      StSendLo:     w_state_next = StWaitLoAck;
      StWaitLoAck:  if (i_tx_busy) w_state_next = StWaitLoDone;
      StWaitLoDone: if (!i_tx_busy) w_state_next = StIdle;
      default:      w_state_next = StIdle;
    endcase
  end

  assign o_fir_in       = r_fir_in;
  assign o_fir_in_valid = r_fir_in_valid;
  assign o_tx_data      = r_tx_data;
  assign o_tx_start     = (r_state == StSendHi) || (r_state == StSendLo);
  assign o_busy         = ~w_empty | (r_state != StIdle);
  assign o_overflow     = r_overflow;
  assign o_fifo_count   = r_count;

endmodule

// File: tb/tb_fir_uart_ctrl.sv
// Randomized bench for fir_uart_ctrl: UART TX responder plus a queue-based model of the byte stream.
module tb_fir_uart_ctrl;

  localparam int DEPTH = 4;
`ifdef FIR_UART_CTRL_SAT8_EN
  localparam int BPW = 1;
`else
  localparam int BPW = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  fir_in;
  logic        fir_in_valid;
  logic [15:0] fir_out;
  logic        fir_out_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  fir_uart_ctrl #(
    .DATA_W    (8),
    .RES_W     (16),
    .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_rx_data      (rx_data),
    .i_rx_done      (rx_done),
    .o_fir_in       (fir_in),
    .o_fir_in_valid (fir_in_valid),
    .i_fir_out      (fir_out),
    .i_fir_out_valid(fir_out_valid),
    .o_tx_data      (tx_data),
    .o_tx_start     (tx_start),
    .i_tx_busy      (tx_busy),
    .o_busy         (busy),
    .o_overflow     (overflow),
    .o_fifo_count   (fifo_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // UART TX responder: records each requested byte, then stays busy for a few cycles.
  logic       model_busy = 1'b0;
  logic       hold_busy  = 1'b0;
  logic       tx_track   = 1'b0;
  logic [7:0] cur_byte   = 8'h00;
  int         busy_left  = 0;
  int         proto_err  = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         cmp_idx = 0;

  assign tx_busy = model_busy | hold_busy;

  always @(negedge clk) begin
    if (rst) tx_track = 1'b0;
    if (tx_start) begin
      if (tx_busy) proto_err++;
      got_q.push_back(tx_data);
      cur_byte   = tx_data;
      tx_track   = 1'b1;
      model_busy = 1'b1;
      busy_left  = $urandom_range(2, 6);
    end else if (model_busy) begin
      if (tx_track && tx_data != cur_byte) proto_err++;
      if (busy_left <= 1) model_busy = 1'b0;
      else busy_left--;
    end
  end

  function automatic void push_exp(input logic [15:0] w);
`ifdef FIR_UART_CTRL_SAT8_EN
    int v;
    v = int'($signed(w));
    if (v > 127) exp_q.push_back(8'h7f);
    else if (v < -128) exp_q.push_back(8'h80);
    else exp_q.push_back(w[7:0]);
`else
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
`endif
  endfunction

  task automatic push_word(input logic [15:0] w);
    fir_out       = w;
    fir_out_valid = 1'b1;
    @(negedge clk);
    fir_out_valid = 1'b0;
    fir_out       = 16'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || tx_busy || got_q.size() < exp_q.size()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_done", 32'(n < 3000), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (cmp_idx < got_q.size() && cmp_idx < exp_q.size()) begin
      check_eq({tag, "_byte"}, 32'(got_q[cmp_idx]), 32'(exp_q[cmp_idx]));
      cmp_idx++;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  dir [4];
    logic [7:0]  last_acc;
    logic        exp_v;
    logic        dn;
    logic        st;
    logic [7:0]  d;
    logic [15:0] w;
    logic [15:0] words [5];
    logic [7:0]  first_exp;
    int          base;
    int          pushed;
    int          guard;

    dir = '{8'h40, 8'h46, 8'h66, 8'h66};
    rst = 1'b1; start = 1'b0; rx_data = '0; rx_done = 1'b0;
    fir_out = '0; fir_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_fir_in", 32'(fir_in), 32'd0);
    check_eq("rst_fir_in_valid", 32'(fir_in_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;

    // Sample path: directed bytes with start=1, then start=0, then random traffic.
    last_acc = 8'h00;
    exp_v    = 1'b0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      check_eq("fir_in_valid", 32'(fir_in_valid), 32'(exp_v));
      check_eq("fir_in", 32'(fir_in), 32'(last_acc));
      check_eq("busy_no_results", 32'(busy), 32'd0);
      if (i < 4) begin
        dn = 1'b1; st = 1'b1; d = dir[i];
      end else if (i < 8) begin
        dn = 1'b1; st = 1'b0; d = dir[i-4];
      end else begin
        dn = 1'($urandom); st = 1'($urandom); d = 8'($urandom);
      end
      rx_done = dn; start = st; rx_data = d;
      exp_v = dn & st;
      if (exp_v) last_acc = d;
    end
    @(negedge clk);
    check_eq("fir_in_valid_last", 32'(fir_in_valid), 32'(exp_v));
    check_eq("fir_in_last", 32'(fir_in), 32'(last_acc));
    rx_done = 1'b0;

    // Single result 0x1234.
    start = 1'b1;
    push_word(16'h1234);
    push_exp(16'h1234);
    wait_drain();
    check_stream("word_1234");
    check_eq("busy_after_1234", 32'(busy), 32'd0);

    // Random results with random gaps; never more than DEPTH words outstanding.
    base   = got_q.size();
    pushed = 0;
    for (int i = 0; i < 30; i++) begin
      start = 1'($urandom);
      repeat ($urandom_range(0, 12)) @(negedge clk);
      guard = 0;
      while (pushed - (got_q.size() - base + BPW - 1) / BPW >= DEPTH && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      check_eq("space_wait", 32'(guard < 500), 32'd1);
      w = 16'($urandom);
      push_word(w);
      push_exp(w);
      pushed++;
    end
    wait_drain();
    check_stream("random");
    check_eq("random_overflow", 32'(overflow), 32'd0);
    check_eq("random_count", 32'(fifo_count), 32'd0);

    // Full FIFO with a push landing in the LOAD (pop) cycle: accepted, no drop.
    pulse_rst();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      push_word(w);
      push_exp(w);
    end
    check_eq("full_count", 32'(fifo_count), 32'd4);
    check_eq("full_no_ovf", 32'(overflow), 32'd0);
    hold_busy = 1'b0;
    @(negedge clk);
    w = 16'($urandom);
    push_word(w);
    push_exp(w);
    check_eq("push_pop_count", 32'(fifo_count), 32'd4);
    check_eq("push_pop_no_ovf", 32'(overflow), 32'd0);
    wait_drain();
    check_stream("push_pop");

    // Overflow: five results while TX is stalled; only the first four survive.
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      words[i] = 16'($urandom);
      push_word(words[i]);
      if (i < 4) push_exp(words[i]);
    end
    check_eq("ovf_count", 32'(fifo_count), 32'd4);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_busy", 32'(busy), 32'd1);
    hold_busy = 1'b0;
    wait_drain();
    check_stream("overflow");
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    check_eq("ovf_drained", 32'(fifo_count), 32'd0);

    // Reset while waiting for the first byte to finish: nothing further is sent.
    pulse_rst();
    base = got_q.size();
    push_word(16'habcd);
    guard = 0;
    while (got_q.size() == base && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("midframe_start", 32'(got_q.size()), 32'(base + 1));
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_fir_in", 32'(fir_in), 32'd0);
    check_eq("mid_rst_fir_in_valid", 32'(fir_in_valid), 32'd0);
    check_eq("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_overflow", 32'(overflow), 32'd0);
    check_eq("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    hold_busy = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("mid_rst_no_more", 32'(got_q.size()), 32'(base + 1));
    exp_q.delete();
    push_exp(16'habcd);
    first_exp = exp_q[0];
    if (got_q.size() > base) check_eq("mid_rst_first_byte", 32'(got_q[base]), 32'(first_exp));

    check_eq("tx_protocol", 32'(proto_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
